// File: rtl/detect_event_logger.sv
// Timestamps rising edges of an upstream detector into a small FIFO and keeps
// a saturating event count plus a sticky drop flag.
module detect_event_logger #(
   parameter int DEPTH = 4,
   parameter int TS_W  = 16,
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_detect,
   input  logic             i_clear,
   input  logic             i_ts_ready,
   output logic             o_ts_valid,
   output logic [TS_W-1:0]  o_ts_data,
   output logic [CNT_W-1:0] o_count,
   output logic             o_overflow
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

   logic [TS_W-1:0]  mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      occ;
   logic             d_prev;
   logic [TS_W-1:0]  timer;
   logic [CNT_W-1:0] count;
   logic             overflow;

   logic det_event;
   logic fifo_full;
   logic pop;
   logic push;

   // A pop frees the slot the same edge, so a full FIFO still accepts a push
   // when the consumer is draining it.
   always_comb begin
      det_event = i_detect & ~d_prev;
      fifo_full = (occ == FULL_OCC);
      pop       = (occ != '0) & i_ts_ready;
      push      = det_event & (~fifo_full | pop);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         d_prev   <= 1'b0;
         timer    <= '0;
         count    <= '0;
         overflow <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         occ      <= '0;
      end else begin
         d_prev <= i_detect;
         if (i_clear) begin
            timer    <= '0;
            count    <= '0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
         end else begin
            timer <= timer + TS_W'(1);
            if (det_event && (count != '1))
               count <= count + CNT_W'(1);
            if (det_event && fifo_full && !pop)
               overflow <= 1'b1;
            if (push)
               wr_ptr <= wr_ptr + AW'(1);
            if (pop)
               rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
               2'b10:   occ <= occ + (AW+1)'(1);
               2'b01:   occ <= occ - (AW+1)'(1);
               default: occ <= occ;
            endcase
         end
      end
   end

   // Storage needs no reset; occupancy alone decides what is visible.
   always_ff @(posedge i_clk) begin
      if (push && !i_clear)
         mem[wr_ptr] <= timer;
   end

   assign o_ts_valid = (occ != '0);
   assign o_ts_data  = o_ts_valid ? mem[rd_ptr] : '0;
   assign o_count    = count;
   assign o_overflow = overflow;

endmodule

// File: tb/tb_detect_event_logger.sv
// Self-checking bench for detect_event_logger: directed table, corner-case
// sequences and randomized traffic against a queue-based reference model.
module tb_detect_event_logger;

   localparam int DEPTH   = 4;
   localparam int TS_W    = 16;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             detect = 1'b0;
   logic             clear = 1'b0;
   logic             ts_ready = 1'b0;
   logic             ts_valid;
   logic [TS_W-1:0]  ts_data;
   logic [CNT_W-1:0] count;
   logic             overflow;

   int vectors = 0;
   int miscompares = 0;

   // reference model state
   int m_q[$];
   int m_count;
   int m_timer;
   bit m_ovf;
   bit m_dprev;

   typedef struct {
      bit d;
      bit c;
      bit r;
      bit exp_valid;
      int exp_data;
      int exp_count;
      bit exp_ovf;
   } vec_t;

   vec_t table_v[12];

   detect_event_logger #(.DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_detect   (detect),
      .i_clear    (clear),
      .i_ts_ready (ts_ready),
      .o_ts_valid (ts_valid),
      .o_ts_data  (ts_data),
      .o_count    (count),
      .o_overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_count = 0;
      m_timer = 0;
      m_ovf   = 0;
      m_dprev = 0;
   endtask

   task automatic model_edge(input bit d, input bit c, input bit r);
      bit ev;
      bit pop;
      ev  = d && !m_dprev;
      pop = (m_q.size() > 0) && r;
      if (c) begin
         m_q.delete();
         m_count = 0;
         m_timer = 0;
         m_ovf   = 0;
      end else begin
         if (pop) void'(m_q.pop_front());
         if (ev) begin
            if (m_q.size() < DEPTH) m_q.push_back(m_timer);
            else m_ovf = 1;
            if (m_count < CNT_MAX) m_count++;
         end
         m_timer = (m_timer + 1) % (1 << TS_W);
      end
      m_dprev = d;
   endtask

   task automatic check_output(input string tag);
      check_val({tag, ".valid"}, int'(ts_valid), (m_q.size() > 0) ? 1 : 0);
      check_val({tag, ".data"}, int'(ts_data), (m_q.size() > 0) ? m_q[0] : 0);
      check_val({tag, ".count"}, int'(count), m_count);
      check_val({tag, ".ovf"}, int'(overflow), int'(m_ovf));
   endtask

   // Drives one cycle of inputs, advances the model on the edge, samples 1 ns later.
   task automatic apply_stimulus(input bit d, input bit c, input bit r);
      detect   = d;
      clear    = c;
      ts_ready = r;
      @(posedge clk);
      model_edge(d, c, r);
      #1;
   endtask

   initial begin
      int exp_drain[4];
      int delivered;

      // timer before edge i equals i right after reset release
      for (int i = 0; i < 5; i++) table_v[i] = '{0, 0, 1, 0, 0, 0, 0};
      table_v[5]  = '{1, 0, 0, 1, 5, 1, 0};
      table_v[6]  = '{0, 0, 0, 1, 5, 1, 0};
      table_v[7]  = '{1, 0, 0, 1, 5, 2, 0};
      table_v[8]  = '{1, 0, 0, 1, 5, 2, 0};
      table_v[9]  = '{1, 0, 1, 1, 7, 2, 0};
      table_v[10] = '{0, 0, 1, 0, 0, 2, 0};
      table_v[11] = '{0, 1, 0, 0, 0, 0, 0};

      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_output("reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         apply_stimulus(table_v[i].d, table_v[i].c, table_v[i].r);
         check_val($sformatf("tbl%0d.valid", i), int'(ts_valid), int'(table_v[i].exp_valid));
         check_val($sformatf("tbl%0d.data", i), int'(ts_data), table_v[i].exp_data);
         check_val($sformatf("tbl%0d.count", i), int'(count), table_v[i].exp_count);
         check_val($sformatf("tbl%0d.ovf", i), int'(overflow), int'(table_v[i].exp_ovf));
      end

      // five pulses into a four-deep FIFO, timer restarted at 0 by the clear
      for (int t = 0; t < 12; t++)
         apply_stimulus((t >= 2) && (t <= 10) && (t % 2 == 0), 0, 0);
      check_val("full.count", int'(count), 5);
      check_val("full.ovf", int'(overflow), 1);
      exp_drain = '{2, 4, 6, 8};
      for (int k = 0; k < 4; k++) begin
         check_val($sformatf("drain%0d.valid", k), int'(ts_valid), 1);
         check_val($sformatf("drain%0d.data", k), int'(ts_data), exp_drain[k]);
         apply_stimulus(0, 0, 1);
      end
      check_val("drained.valid", int'(ts_valid), 0);
      check_val("drained.ovf", int'(overflow), 1);

      // simultaneous push and pop while full, then clear beating a pulse
      apply_stimulus(0, 1, 0);
      for (int i = 0; i < 8; i++) apply_stimulus(i % 2 == 0, 0, 0);
      check_output("fill4");
      apply_stimulus(1, 0, 1);
      check_output("fullpp");
      check_val("fullpp.ovf_const", int'(overflow), 0);
      check_val("fullpp.head", int'(ts_data), 2);
      apply_stimulus(0, 0, 0);
      apply_stimulus(1, 1, 0);
      check_output("clrpulse");
      check_val("clrpulse.count_const", int'(count), 0);
      apply_stimulus(1, 0, 0);
      check_output("clr_dprev");

      // counter saturation with all timestamps still delivered
      apply_stimulus(0, 1, 0);
      delivered = 0;
      for (int i = 0; i < 36; i++) begin
         if (ts_valid) delivered++;
         apply_stimulus((i < 34) && (i % 2 == 0), 0, 1);
         check_output($sformatf("sat%0d", i));
      end
      check_val("sat.count", int'(count), 15);
      check_val("sat.delivered", delivered, 17);

      // asynchronous reset with a non-empty FIFO, detect high at release
      apply_stimulus(1, 0, 0);
      apply_stimulus(0, 0, 0);
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      check_output("midreset");
      @(negedge clk);
      detect   = 1'b1;
      ts_ready = 1'b1;
      rst_n    = 1'b1;
      apply_stimulus(1, 0, 1);
      check_output("release");
      check_val("release.count", int'(count), 1);

      for (int i = 0; i < 600; i++) begin
         apply_stimulus($urandom_range(0, 99) < 40,
                        $urandom_range(0, 99) < 2,
                        $urandom_range(0, 99) < 35);
         check_output($sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/detect_event_logger.md
DETECT_EVENT_LOGGER -- requirements
Module: detect_event_logger

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning timestamp FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter TS_W, default 16, meaning timestamp and free-running timer width.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning detection counter width.
REQ-004 The block SHALL have port i_clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port i_rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-006 The block SHALL have port i_detect, input, 1, meaning the detector output from the upstream sequence detector.
REQ-007 The block SHALL have port i_clear, input, 1, meaning synchronous soft clear of all logger state.
REQ-008 The block SHALL have port i_ts_ready, input, 1, meaning the consumer accepts the head timestamp.
REQ-009 The block SHALL have port o_ts_valid, output, 1, meaning the FIFO is non-empty and o_ts_data is valid.
REQ-010 The block SHALL have port o_ts_data, output, TS_W, meaning the head-of-FIFO timestamp.
REQ-011 The block SHALL have port o_count, output, CNT_W, meaning the saturating count of detection events.
REQ-012 The block SHALL have port o_overflow, output, 1, meaning sticky flag: an event was dropped because the FIFO was full.

Function
REQ-013 The block SHALL register i_detect into d_prev each cycle; an event SHALL be i_detect=1 with d_prev=0 (rising edge), so a multi-cycle high counts once.
REQ-014 A free-running TS_W timer SHALL increment by 1 every cycle and wrap from all-ones to 0 without any flag.
REQ-015 On an event at edge N, the timer value sampled at edge N SHALL be pushed; o_count SHALL show the increment after edge N (one-cycle latency).
REQ-016 o_count SHALL saturate at all-ones; further events SHALL still be pushed to the FIFO.
REQ-017 A pop SHALL occur on any edge where o_ts_valid=1 and i_ts_ready=1; o_ts_data SHALL stay stable while o_ts_valid=1 and i_ts_ready=0.
REQ-018 There SHALL be no fall-through: a push into an empty FIFO SHALL raise o_ts_valid on the following cycle.
REQ-019 Push when full without pop SHALL drop the timestamp, set o_overflow, and still increment o_count; FIFO contents SHALL be unchanged.
REQ-020 Push and pop on the same edge while full SHALL both succeed; occupancy stays DEPTH; o_overflow unchanged.
REQ-021 Push and pop on the same edge with occupancy between 1 and DEPTH-1 SHALL leave occupancy unchanged.
REQ-022 Read/write pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked with a log2(DEPTH)+1-bit counter.
REQ-023 i_clear=1 SHALL, at that edge, empty the FIFO, zero o_count, timer and o_overflow; clear SHALL take priority over a same-cycle event or pop (both discarded); d_prev SHALL still be updated.
REQ-024 i_ts_ready while o_ts_valid=0 SHALL have no effect.

Reset
REQ-025 While i_rst_n=0: o_ts_valid=0, o_ts_data=0, o_count=0, o_overflow=0, timer=0, d_prev=0, pointers and occupancy=0.
REQ-026 Reset assertion mid-operation SHALL discard all FIFO contents immediately; no pop SHALL occur at the first edge after release.
REQ-027 If i_detect=1 at the first edge after reset release, it SHALL count as an event (d_prev=0).

Verification
REQ-028 Reset then idle 10 cycles, i_ts_ready=1 -> o_ts_valid=0, o_count=0, o_overflow=0 throughout.
REQ-029 One-cycle pulse at timer=5, i_ts_ready=0 -> next cycle o_count=1, o_ts_valid=1, o_ts_data=5; held until ready, then o_ts_valid=0 after pop.
REQ-030 i_detect high 3 cycles at timer=7..9 -> o_count=1, single entry with o_ts_data=7.
REQ-031 DEPTH=4, i_ts_ready=0, five pulses at timers 2,4,6,8,10 -> o_count=5, o_overflow=1, drain yields 2,4,6,8 in order.
REQ-032 Full FIFO, pulse coinciding with i_ts_ready=1 -> head popped, new timestamp appended, occupancy 4, o_overflow stays 0; then i_clear with a same-cycle pulse -> o_ts_valid=0, o_count=0, o_overflow=0 next cycle.
REQ-033 CNT_W=4, 17 separated pulses with i_ts_ready=1 -> o_count stops at 15; all 17 timestamps delivered.
